// File: rtl/branch_predictor_gs_pkg.sv
// Shared types, constants and width helpers for the gshare branch predictor and its return address stack.
package branch_predictor_gs_pkg;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } cnt_state_e;

    // Link registers that mark a call (as Rd) or a return (as Rs1).
    localparam logic [4:0] LINK_X1 = 5'd1;
    localparam logic [4:0] LINK_X5 = 5'd5;

    function automatic int calc_iw(input int bht_entries);
        return $clog2(bht_entries);
    endfunction

    function automatic int calc_gw(input int ghr_bits);
        return (ghr_bits > 0) ? ghr_bits : 1;
    endfunction

    function automatic int calc_pw(input int ras_depth);
        return $clog2(ras_depth);
    endfunction

    function automatic int calc_cw(input int ras_depth);
        return $clog2(ras_depth) + 1;
    endfunction

    localparam int IW = calc_iw(64);
    localparam int GW = calc_gw(6);
    localparam int PW = calc_pw(4);
    localparam int CW = calc_cw(4);

    function automatic logic is_link_reg(input logic [4:0] reg_num);
        return (reg_num == LINK_X1) || (reg_num == LINK_X5);
    endfunction

    function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
        if (taken)
            return (cnt == ST) ? cnt : cnt + 2'd1;
        return (cnt == SNT) ? cnt : cnt - 2'd1;
    endfunction

endpackage

// File: rtl/branch_predictor_gs_if.sv
// Fetch/resolve bus between the pipeline (master) and the branch predictor (slave).
interface branch_predictor_gs_if #(
    parameter int PC_WIDTH  = 32,
    parameter int GHR_BITS  = 6,
    parameter int RAS_DEPTH = 4
);
    import branch_predictor_gs_pkg::*;

    localparam int HIST_W = calc_gw(GHR_BITS);
    localparam int PTR_W  = calc_pw(RAS_DEPTH);
    localparam int CNT_W  = calc_cw(RAS_DEPTH);

    logic                stall;
    logic                flush;
    logic [PC_WIDTH-1:0] pred_pc;
    logic                pred_btype;
    logic                pred_taken;
    logic [HIST_W-1:0]   pred_ghr;
    logic [PTR_W-1:0]    pred_ras_ptr;
    logic [CNT_W-1:0]    pred_ras_cnt;
    logic                ras_push;
    logic [PC_WIDTH-1:0] ras_push_addr;
    logic                ras_pop;
    logic [PC_WIDTH-1:0] ras_top;
    logic                ras_valid;
    logic                upd_en;
    logic [PC_WIDTH-1:0] upd_pc;
    logic [HIST_W-1:0]   upd_ghr;
    logic                upd_taken;
    logic                upd_mispredict;
    logic [PTR_W-1:0]    upd_ras_ptr;
    logic [CNT_W-1:0]    upd_ras_cnt;

    modport master (
        output stall, flush, pred_pc, pred_btype,
        output ras_push, ras_push_addr, ras_pop,
        output upd_en, upd_pc, upd_ghr, upd_taken, upd_mispredict, upd_ras_ptr, upd_ras_cnt,
        input  pred_taken, pred_ghr, pred_ras_ptr, pred_ras_cnt, ras_top, ras_valid
    );

    modport slave (
        input  stall, flush, pred_pc, pred_btype,
        input  ras_push, ras_push_addr, ras_pop,
        input  upd_en, upd_pc, upd_ghr, upd_taken, upd_mispredict, upd_ras_ptr, upd_ras_cnt,
        output pred_taken, pred_ghr, pred_ras_ptr, pred_ras_cnt, ras_top, ras_valid
    );

endinterface

// File: rtl/branch_predictor_gs_ras_stack.sv
// Circular return address stack: speculative push/pop/coroutine-swap plus pointer/count repair
// from a checkpoint. Entries themselves are never restored.
module ras_stack
    import branch_predictor_gs_pkg::*;
#(
    parameter  int PC_WIDTH  = 32,
    parameter  int RAS_DEPTH = 4,
    localparam int PTR_W     = calc_pw(RAS_DEPTH),
    localparam int CNT_W     = calc_cw(RAS_DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic                flush,
    input  logic                push,
    input  logic [PC_WIDTH-1:0] push_addr,
    input  logic                pop,
    input  logic                repair,
    input  logic [PTR_W-1:0]    repair_ptr,
    input  logic [CNT_W-1:0]    repair_cnt,
    output logic [PC_WIDTH-1:0] top,
    output logic                valid,
    output logic [PTR_W-1:0]    ptr,
    output logic [CNT_W-1:0]    cnt
);

    logic [PC_WIDTH-1:0] entries [RAS_DEPTH];
    logic [PTR_W-1:0]    ptr_m1;
    logic                empty;
    logic                full;
    logic                spec_ok;
    logic                do_push;
    logic                do_pop;
    logic                do_swap;

    assign ptr_m1  = ptr - PTR_W'(1);
    assign empty   = (cnt == '0);
    assign full    = (cnt == CNT_W'(RAS_DEPTH));
    assign spec_ok = !stall && !flush;

    // A coroutine swap on an empty stack degenerates into a plain push.
    assign do_swap = spec_ok && push && pop && !empty;
    assign do_push = spec_ok && push && (!pop || empty);
    assign do_pop  = spec_ok && pop && !push && !empty;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
            cnt <= '0;
        end else if (repair) begin
            ptr <= repair_ptr;
            cnt <= repair_cnt;
        end else if (do_push) begin
            ptr <= ptr + PTR_W'(1);
            if (!full)
                cnt <= cnt + CNT_W'(1);
        end else if (do_pop) begin
            ptr <= ptr_m1;
            cnt <= cnt - CNT_W'(1);
        end
    end

    // NOTE: this storage is reset on purpose so ras_top reads 0 after reset; a plain RAM would not be.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RAS_DEPTH; i++)
                entries[i] <= '0;
        end else if (do_push) begin
            entries[ptr] <= push_addr;
        end else if (do_swap) begin
            entries[ptr_m1] <= push_addr;
        end
    end

    assign top   = entries[ptr_m1];
    assign valid = !empty;

endmodule

// File: rtl/branch_predictor_gs.sv
// IF-stage branch predictor: gshare (or bimodal when GHR_BITS=0) direction table with a
// checkpoint-repaired global history, plus a return address stack for jalr targets.
module branch_predictor_gs
    import branch_predictor_gs_pkg::*;
#(
    parameter int         PC_WIDTH    = 32,
    parameter int         BHT_ENTRIES = 64,
    parameter int         GHR_BITS    = 6,
    parameter int         RAS_DEPTH   = 4,
    parameter logic [1:0] CNT_INIT    = WNT
) (
    input logic                  clk,
    input logic                  rst_n,
    branch_predictor_gs_if.slave bus
);

    localparam int IDX_W  = calc_iw(BHT_ENTRIES);
    localparam int HIST_W = calc_gw(GHR_BITS);
    localparam int PTR_W  = calc_pw(RAS_DEPTH);
    localparam int CNT_W  = calc_cw(RAS_DEPTH);

    logic [1:0]        bht [BHT_ENTRIES];
    logic [HIST_W-1:0] ghr;
    logic [IDX_W-1:0]  pred_hist;
    logic [IDX_W-1:0]  upd_hist;
    logic [IDX_W-1:0]  pred_idx;
    logic [IDX_W-1:0]  upd_idx;
    logic              pred_taken;
    logic              repair;
    logic              unused_bits;

    assign repair = bus.flush && bus.upd_mispredict;

    if (GHR_BITS == 0) begin : g_bimodal
        assign ghr       = '0;
        assign pred_hist = '0;
        assign upd_hist  = '0;
    end else begin : g_gshare
        assign pred_hist = IDX_W'(ghr);
        assign upd_hist  = IDX_W'(bus.upd_ghr);

        // Repair rebuilds history from the branch's own snapshot, so it outranks the
        // speculative shift of whatever is being fetched in the same cycle.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                ghr <= '0;
            else if (repair)
                ghr <= (bus.upd_ghr << 1) | HIST_W'(bus.upd_taken);
            else if (bus.pred_btype && !bus.stall && !bus.flush)
                ghr <= (ghr << 1) | HIST_W'(pred_taken);
        end
    end

    assign pred_idx = bus.pred_pc[IDX_W+1:2] ^ pred_hist;
    assign upd_idx  = bus.upd_pc[IDX_W+1:2] ^ upd_hist;

    // Resolved outcomes are architectural, so the table trains even while stalled or flushing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++)
                bht[i] <= CNT_INIT;
        end else if (bus.upd_en) begin
            bht[upd_idx] <= sat_update(bht[upd_idx], bus.upd_taken);
        end
    end

    assign pred_taken     = bht[pred_idx][1];
    assign bus.pred_taken = pred_taken;
    assign bus.pred_ghr   = ghr;

    ras_stack #(
        .PC_WIDTH  (PC_WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (bus.stall),
        .flush      (bus.flush),
        .push       (bus.ras_push),
        .push_addr  (bus.ras_push_addr),
        .pop        (bus.ras_pop),
        .repair     (repair),
        .repair_ptr (bus.upd_ras_ptr),
        .repair_cnt (bus.upd_ras_cnt),
        .top        (bus.ras_top),
        .valid      (bus.ras_valid),
        .ptr        (bus.pred_ras_ptr),
        .cnt        (bus.pred_ras_cnt)
    );

    // Only the index bits of the PCs feed the table; history is ignored in bimodal mode.
    assign unused_bits = ^{bus.pred_pc, bus.upd_pc, bus.upd_ghr};

endmodule
